// File: rtl/uart_tx_buffer_pkg.sv
// rtl/uart_tx_buffer_pkg.sv - shared constants and FSM encoding for the UART TX byte buffer
//
// Purpose: single home for the data width, the default FIFO depth and the
// send-controller state encoding used by uart_tx_buffer and uart_tx_fifo_mem.
// Ports: none (package).

package uart_tx_buffer_pkg;

  localparam int DATA_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_BUSY = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// rtl/uart_tx_buffer_if.sv - Core/transmitter handshake bundle for uart_tx_buffer
//
// Purpose: groups the push strobe from the Core, the DV/Done handshake with the
// UART transmitter and the FIFO status flags.
// Ports (signals):
//   Wr_DV_in, Wr_Byte_in   push strobe and byte from the Core
//   Tx_Done_in             one-cycle done pulse from the transmitter
//   Tx_DV_out, Tx_Byte_out start strobe and byte to the transmitter
//   Full_out, Empty_out    registered FIFO flags
//   Count_out              entries stored (ADDR_W+1 bits)
//   Overflow_out           sticky drop flag, only with UART_TX_OVF_FLAG_EN
// Modports: master = Core/transmitter side, slave = the buffer.
// Build option: UART_TX_OVF_FLAG_EN adds Overflow_out.

interface uart_tx_buffer_if
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              Wr_DV_in;
  logic [DATA_W-1:0] Wr_Byte_in;
  logic              Tx_Done_in;
  logic              Tx_DV_out;
  logic [DATA_W-1:0] Tx_Byte_out;
  logic              Full_out;
  logic              Empty_out;
  logic [ADDR_W:0]   Count_out;
`ifdef UART_TX_OVF_FLAG_EN
  logic              Overflow_out;

  modport master (
    output Wr_DV_in, Wr_Byte_in, Tx_Done_in,
    input  Tx_DV_out, Tx_Byte_out, Full_out, Empty_out, Count_out, Overflow_out
  );

  modport slave (
    input  Wr_DV_in, Wr_Byte_in, Tx_Done_in,
    output Tx_DV_out, Tx_Byte_out, Full_out, Empty_out, Count_out, Overflow_out
  );
`else
  modport master (
    output Wr_DV_in, Wr_Byte_in, Tx_Done_in,
    input  Tx_DV_out, Tx_Byte_out, Full_out, Empty_out, Count_out
  );

  modport slave (
    input  Wr_DV_in, Wr_Byte_in, Tx_Done_in,
    output Tx_DV_out, Tx_Byte_out, Full_out, Empty_out, Count_out
  );
`endif

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - circular byte store with pointers, count and flags
//
// Purpose: DEPTH-entry byte FIFO. The caller only pushes when there is room
// (or a pop happens in the same cycle) and only pops when not empty.
// Ports:
//   CLK        system clock
//   RST        asynchronous active-low reset
//   push       store push_byte at the write pointer this cycle
//   push_byte  byte to store
//   pop        advance the read pointer this cycle
//   head_byte  byte at the read pointer (combinational)
//   count      entries stored, 0..DEPTH
//   full       registered, count == DEPTH
//   empty      registered, count == 0

module uart_tx_fifo_mem
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_byte,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_byte,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              full_q;
  logic              empty_q;

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  assign head_byte = mem[rd_ptr];
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte FIFO plus DV/Done send controller feeding a UART transmitter
//
// Purpose: absorbs bursts of bytes from the Core and replays them one at a
// time to the transmitter. A byte is popped on the IDLE->SEND transition,
// Tx_DV_out is high for the single SEND cycle, and BUSY waits for Tx_Done_in.
// Ports:
//   CLK   system clock
//   RST   asynchronous active-low reset
//   bus   uart_tx_buffer_if.slave (push, DV/Done handshake, status flags)
// Build option: UART_TX_OVF_FLAG_EN adds the sticky Overflow_out flag.
// The DEPTH parameter must match the DEPTH of the connected interface.

module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_buffer_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_byte;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              tx_dv_q;
  logic [DATA_W-1:0] tx_byte_q;
`ifdef UART_TX_OVF_FLAG_EN
  logic              drop;
  logic              ovf_q;
`endif

  uart_tx_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_byte (bus.Wr_Byte_in),
    .pop       (pop),
    .head_byte (head_byte),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A push into a full FIFO still fits when the head leaves in the same cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    push    = 1'b0;
`ifdef UART_TX_OVF_FLAG_EN
    drop    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_BUSY;
      ST_BUSY: begin
        if (bus.Tx_Done_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.Wr_DV_in) begin
      if (!fifo_full || pop) begin
        push = 1'b1;
      end else begin
`ifdef UART_TX_OVF_FLAG_EN
        drop = 1'b1;
`endif
      end
    end
  end

  // DV rises with the pop edge, so it is high exactly for the SEND cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_dv_q <= pop;
      if (pop) begin
        tx_byte_q <= head_byte;
      end
    end
  end

`ifdef UART_TX_OVF_FLAG_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.Overflow_out = ovf_q;
`endif

  assign bus.Tx_DV_out   = tx_dv_q;
  assign bus.Tx_Byte_out = tx_byte_q;
  assign bus.Full_out    = fifo_full;
  assign bus.Empty_out   = fifo_empty;
  assign bus.Count_out   = fifo_count;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - self-checking bench for uart_tx_buffer

module tb_uart_tx_buffer;
  import uart_tx_buffer_pkg::*;

  localparam int DEPTH = DEFAULT_DEPTH;

  logic       CLK = 1'b0;
  logic       RST;
  logic       wr_dv = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       man_done = 1'b0;
  logic       auto_done = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.Wr_DV_in   = wr_dv;
  assign bus.Wr_Byte_in = wr_byte;
  assign bus.Tx_Done_in = man_done | auto_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Transmitter model and DV monitor, both sampling on the falling edge.
  bit         auto_en = 1'b0;
  int         lat = 5;
  int         timer = 0;
  logic [7:0] rx_q[$];
  int         dv_cyc_q[$];
  int         done_cyc_q[$];
  int         dv_count = 0;
  logic       prev_dv = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      timer     = 0;
      auto_done = 1'b0;
      prev_dv   = 1'b0;
    end else begin
      if (bus.Tx_DV_out) begin
        rx_q.push_back(bus.Tx_Byte_out);
        dv_cyc_q.push_back(cyc);
        dv_count++;
        if (prev_dv) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dv_width: got 2 consecutive DV cycles expected 1 at cycle %0d", cyc);
        end
      end
      prev_dv   = bus.Tx_DV_out;
      auto_done = 1'b0;
      if (auto_en) begin
        if (bus.Tx_DV_out) begin
          timer = lat;
        end else if (timer > 0) begin
          timer--;
          if (timer == 0) begin
            auto_done = 1'b1;
            done_cyc_q.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    tick();
    RST      = 1'b0;
    wr_dv    = 1'b0;
    man_done = 1'b0;
    auto_en  = 1'b0;
    repeat (2) tick();
    rx_q.delete();
    dv_cyc_q.delete();
    done_cyc_q.delete();
    dv_count = 0;
    RST      = 1'b1;
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_dv   = 1'b1;
      wr_byte = first + 8'(i);
      tick();
    end
    wr_dv = 1'b0;
  endtask

  task automatic wait_dv(input string nm, input int target, input int budget);
    int k = 0;
    while (dv_count < target && k < budget) begin
      tick();
      k++;
    end
    chk({nm, "_dv_timeout"}, 32'(dv_count >= target), 1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_dv"}, 32'(bus.Tx_DV_out), 0);
    chk({nm, "_byte"}, 32'(bus.Tx_Byte_out), 0);
    chk({nm, "_count"}, 32'(bus.Count_out), 0);
    chk({nm, "_empty"}, 32'(bus.Empty_out), 1);
    chk({nm, "_full"}, 32'(bus.Full_out), 0);
`ifdef UART_TX_OVF_FLAG_EN
    chk({nm, "_ovf"}, 32'(bus.Overflow_out), 0);
`endif
  endtask

  typedef struct {
    logic       push;
    logic [7:0] b;
    logic       done;
    logic       exp_dv;
    logic [7:0] exp_byte;
    int         exp_cnt;
  } vec_t;

  vec_t       tv[13];
  logic [7:0] exp_q[$];

  initial begin
    int p0;
    int pushed;
    int popped;
    int k;
    int d0;
    logic [7:0] b;

    tv[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1};
    tv[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 0};
    tv[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'hA5, 1};
    tv[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'hA5, 2};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 2};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1};
    tv[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 0};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 0};
    tv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 0};
    tv[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 0};

    // Reset state
    RST = 1'b1;
    #1 RST = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (2) tick();
    RST = 1'b1;

    // Table: single push, Done ignored in SEND/IDLE, back-to-back replay
    for (int i = 0; i < 13; i++) begin
      wr_dv    = tv[i].push;
      wr_byte  = tv[i].b;
      man_done = tv[i].done;
      tick();
      chk($sformatf("tv%0d_dv", i), 32'(bus.Tx_DV_out), 32'(tv[i].exp_dv));
      chk($sformatf("tv%0d_byte", i), 32'(bus.Tx_Byte_out), 32'(tv[i].exp_byte));
      chk($sformatf("tv%0d_count", i), 32'(bus.Count_out), 32'(tv[i].exp_cnt));
      chk($sformatf("tv%0d_empty", i), 32'(bus.Empty_out), 32'(tv[i].exp_cnt == 0));
      chk($sformatf("tv%0d_full", i), 32'(bus.Full_out), 32'(tv[i].exp_cnt == DEPTH));
    end
    wr_dv    = 1'b0;
    man_done = 1'b0;

    // Three bytes against a slow transmitter
    do_reset();
    auto_en = 1'b1;
    lat     = 2170;
    p0      = cyc;
    push_seq(8'h01, 3);
    wait_dv("slow", 3, 7000);
    if (rx_q.size() == 3 && done_cyc_q.size() >= 2) begin
      for (int i = 0; i < 3; i++) chk($sformatf("slow_byte%0d", i), 32'(rx_q[i]), 32'(i + 1));
      chk("slow_first_lat", 32'(dv_cyc_q[0] - p0), 2);
      chk("slow_gap1", 32'(dv_cyc_q[1] - done_cyc_q[0]), 2);
      chk("slow_gap2", 32'(dv_cyc_q[2] - done_cyc_q[1]), 2);
    end else begin
      chk("slow_dv_total", 32'(rx_q.size()), 3);
    end

    // Overfill while BUSY: last two bytes dropped
    do_reset();
    auto_en = 1'b1;
    lat     = 40;
    push_seq(8'h50, 1);
    wait_dv("fill_first", 1, 10);
    push_seq(8'h60, DEPTH + 2);
    chk("fill_full", 32'(bus.Full_out), 1);
    chk("fill_count", 32'(bus.Count_out), DEPTH);
`ifdef UART_TX_OVF_FLAG_EN
    chk("fill_ovf", 32'(bus.Overflow_out), 1);
`endif
    wait_dv("fill_drain", DEPTH + 1, (DEPTH + 1) * 45);
    repeat (100) tick();
    chk("fill_total", 32'(dv_count), DEPTH + 1);
    if (rx_q.size() == DEPTH + 1) begin
      chk("fill_byte0", 32'(rx_q[0]), 32'h50);
      for (int i = 0; i < DEPTH; i++) chk($sformatf("fill_byte%0d", i + 1), 32'(rx_q[i + 1]), 32'(8'h60 + i));
    end
`ifdef UART_TX_OVF_FLAG_EN
    chk("fill_ovf_sticky", 32'(bus.Overflow_out), 1);
`endif

    // Full FIFO, push lands on the pop cycle
    do_reset();
    push_seq(8'h80, DEPTH + 1);
    chk("popcyc_full_pre", 32'(bus.Full_out), 1);
    chk("popcyc_count_pre", 32'(bus.Count_out), DEPTH);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    wr_dv    = 1'b1;
    wr_byte  = 8'hEE;
    auto_en  = 1'b1;
    lat      = 6;
    tick();
    wr_dv = 1'b0;
    chk("popcyc_dv", 32'(bus.Tx_DV_out), 1);
    chk("popcyc_byte", 32'(bus.Tx_Byte_out), 32'h81);
    chk("popcyc_count", 32'(bus.Count_out), DEPTH);
    chk("popcyc_full", 32'(bus.Full_out), 1);
`ifdef UART_TX_OVF_FLAG_EN
    chk("popcyc_ovf", 32'(bus.Overflow_out), 0);
`endif
    wait_dv("popcyc_drain", DEPTH + 2, (DEPTH + 2) * 12);
    exp_q.delete();
    for (int i = 0; i <= DEPTH; i++) exp_q.push_back(8'h80 + 8'(i));
    exp_q.push_back(8'hEE);
    chk("popcyc_total", 32'(rx_q.size()), DEPTH + 2);
    if (rx_q.size() == DEPTH + 2) begin
      for (int i = 0; i < DEPTH + 2; i++) chk($sformatf("popcyc_seq%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    end

    // Random paced traffic wrapping the pointers several times
    do_reset();
    auto_en = 1'b1;
    exp_q.delete();
    pushed = 0;
    popped = 0;
    k      = 0;
    while ((pushed < 48 || popped < 48) && k < 3000) begin
      tick();
      k++;
      lat = $urandom_range(1, 6);
      if (bus.Tx_DV_out) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_dv", 32'(bus.Tx_DV_out), 0);
        end else begin
          chk($sformatf("rand_byte%0d", popped), 32'(bus.Tx_Byte_out), 32'(exp_q.pop_front()));
        end
        popped++;
      end
      chk("rand_count", 32'(bus.Count_out), 32'(pushed - popped));
      chk("rand_empty", 32'(bus.Empty_out), 32'(pushed == popped));
      chk("rand_full", 32'(bus.Full_out), 0);
      if (pushed < 48 && (pushed - popped) < DEPTH - 1 && $urandom_range(0, 2) != 0) begin
        b       = 8'($urandom);
        wr_dv   = 1'b1;
        wr_byte = b;
        exp_q.push_back(b);
        pushed++;
      end else begin
        wr_dv = 1'b0;
      end
    end
    wr_dv = 1'b0;
    chk("rand_all_sent", 32'(popped), 48);

    // Reset while BUSY with 5 buffered bytes
    do_reset();
    push_seq(8'hC0, 6);
    repeat (3) tick();
    chk("rst_busy_count", 32'(bus.Count_out), 5);
    chk("rst_busy_byte", 32'(bus.Tx_Byte_out), 32'hC0);
    #2 RST = 1'b0;
    #1 chk_reset_vals("rst_mid");
    tick();
    RST      = 1'b1;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    d0       = dv_count;
    repeat (6) tick();
    chk("rst_late_done", 32'(dv_count), 32'(d0));
    chk("rst_count_after", 32'(bus.Count_out), 0);
    auto_en = 1'b1;
    lat     = 4;
    push_seq(8'h3C, 1);
    wait_dv("rst_fresh", d0 + 1, 10);
    if (rx_q.size() > 0) chk("rst_fresh_byte", 32'(rx_q[rx_q.size() - 1]), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
